// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a scanned,
// active-low 4-digit 7-segment display and reports whole frames.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [10:0]      sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_q, cap_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      dig_q, dig_d;
  logic [3:0]       err_q, err_d;
  logic [15:0]      value_q;
  logic [3:0]       derr_q;
  logic             fv_q;

  logic [3:0] s_an;
  logic [6:0] s_pat;
  logic       valid;
  logic       capture;
  logic       frame_done;
  logic [1:0] idx;
  logic [4:0] dec;

  assign s_an  = sync2_q[10:7];
  assign s_pat = ~sync2_q[6:0];
  assign valid = $onehot(~s_an);
  assign frame_done = (seen_q == 4'hF);

  // gfedcba pattern to {bad, nibble}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign dec = decode(s_pat);

  // index of the (single) low anode
  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!s_an[i]) idx = 2'(i);
    end
  end

  // stability tracking and one-shot capture per stable pattern
  always_comb begin
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    capture = 1'b0;
    if (!valid) begin
      cnt_d = '0;
      cap_d = 1'b0;
    end else if (sync2_q == prev_q) begin
      if (cnt_q < STABLE) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = CNT_W'(1);
      cap_d = 1'b0;
    end
    if (valid && cnt_d == STABLE && !cap_d) begin
      capture = 1'b1;
      cap_d   = 1'b1;
    end
  end

  // digit store; a full mask clears before a same-cycle capture lands
  always_comb begin
    seen_d = frame_done ? 4'h0 : seen_q;
    dig_d  = dig_q;
    err_d  = err_q;
    if (capture) begin
      seen_d[idx] = 1'b1;
      err_d[idx]  = dec[4];
      dig_d[{idx, 2'b00} +: 4] = dec[4] ? 4'h0 : dec[3:0];
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
      cap_q   <= 1'b0;
      seen_q  <= 4'h0;
      dig_q   <= 16'h0;
      err_q   <= 4'h0;
      value_q <= 16'h0;
      derr_q  <= 4'h0;
      fv_q    <= 1'b0;
    end else begin
      sync1_q <= {an_n, seg_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      seen_q  <= seen_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
      fv_q    <= frame_done;
      if (frame_done) begin
        value_q <= dig_q;
        derr_q  <= err_q;
      end
    end
  end

  assign value       = value_q;
  assign digit_err   = derr_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scan sequences
// against a sample-history model of the decoder.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_n(seg_n),
    .an_n(an_n),
    .value(value),
    .digit_err(digit_err),
    .frame_valid(frame_valid)
  );

  logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_pass   = 0;

  // model state: pin samples seen by the decoder, run length
  logic [10:0] m_p1, m_p2, m_prev;
  int          m_run;
  logic [3:0]  m_seen;
  logic [15:0] m_dig, m_val;
  logic [3:0]  m_errr, m_err;
  logic        m_fv;

  int          cyc = 0;
  int          pulses = 0;
  int          last_pulse_cyc = 0;
  logic [15:0] last_val = 16'h0;
  logic [3:0]  last_err = 4'h0;
  int          t_apply = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_p1 = '1; m_p2 = '1; m_prev = '1;
    m_run = 0; m_seen = 0; m_dig = 0; m_errr = 0;
    m_val = 0; m_err = 0; m_fv = 0;
  endtask

  task automatic model_step();
    logic       fv_new;
    logic [3:0] an;
    int         zeros, idx, d;
    fv_new = (m_seen == 4'hF);
    if (fv_new) begin
      m_val  = m_dig;
      m_err  = m_errr;
      m_seen = 4'h0;
    end
    an = m_p2[10:7];
    zeros = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; idx = i; end
    if (zeros == 1) begin
      if (m_p2 == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
    end else begin
      m_run = 0;
    end
    if (m_run == STABLE) begin
      d = decode(~m_p2[6:0]);
      m_seen[idx] = 1'b1;
      if (d < 0) begin
        m_dig[idx*4 +: 4] = 4'h0;
        m_errr[idx] = 1'b1;
      end else begin
        m_dig[idx*4 +: 4] = 4'(d);
        m_errr[idx] = 1'b0;
      end
    end
    m_prev = m_p2;
    m_p2   = m_p1;
    m_p1   = {an_n, seg_n};
    m_fv   = fv_new;
  endtask

  // model advance on posedge, compare on negedge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      cyc++;
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("cycle", 32'({frame_valid, digit_err, value}),
          32'({m_fv, m_err, m_val}));
      if (frame_valid === 1'b1) begin
        pulses++;
        last_val = value;
        last_err = digit_err;
        last_pulse_cyc = cyc;
      end
    end
  end

  task automatic apply(input logic [3:0] an, input logic [6:0] seg,
                       input int n);
    @(negedge clk);
    #1;
    an_n = an;
    seg_n = seg;
    t_apply = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    apply(~(4'b0001 << d), ~p, n);
  endtask

  task automatic blank(input int n);
    apply(4'hF, 7'h7F, n);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    an_n = 4'($urandom);
    seg_n = 7'($urandom);
    #1;
    chk("rst_now", 32'({frame_valid, digit_err, value}), 32'h0);
    repeat (n) begin
      @(negedge clk);
      #1;
      an_n = 4'($urandom);
      seg_n = 7'($urandom);
    end
    @(negedge clk);
    #1;
    an_n = 4'hF;
    seg_n = 7'h7F;
    rst_n = 1'b1;
  endtask

  int p0;
  int tl;

  initial begin
    rst_n = 1'b0;
    an_n = 4'hF;
    seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    do_reset(4);

    // nominal scan 1,2,3,4
    p0 = pulses;
    show(3, 7'h06, 8);
    show(2, 7'h5B, 8);
    show(1, 7'h4F, 8);
    show(0, 7'h66, 8);
    tl = t_apply;
    blank(10);
    chk("nom_pulses", 32'(pulses - p0), 32'd1);
    chk("nom_value", 32'(last_val), 32'h1234);
    chk("nom_err", 32'(last_err), 32'h0);
    chk("nom_latency", 32'(last_pulse_cyc - tl), 32'd7);

    // glitch shorter than the stability window
    p0 = pulses;
    show(0, 7'h7F, 3);
    blank(4);
    show(3, 7'h06, 8);
    show(2, 7'h5B, 8);
    show(1, 7'h4F, 8);
    blank(12);
    chk("glitch_nopulse", 32'(pulses - p0), 32'd0);

    // unrecognised pattern on digit 0
    do_reset(3);
    p0 = pulses;
    show(0, 7'h00, 8);
    show(3, 7'h77, 8);
    show(2, 7'h7C, 8);
    show(1, 7'h39, 8);
    blank(10);
    chk("inv_pulses", 32'(pulses - p0), 32'd1);
    chk("inv_value", 32'(last_val), 32'hABC0);
    chk("inv_err", 32'(last_err), 32'h1);

    // ghosting ignored, then overwrite of digit 2
    do_reset(3);
    p0 = pulses;
    apply(4'b1100, ~7'h06, 20);
    blank(3);
    show(2, 7'h6D, 8);
    show(2, 7'h6F, 8);
    show(3, 7'h06, 8);
    show(1, 7'h5B, 8);
    show(0, 7'h4F, 8);
    blank(10);
    chk("ovr_pulses", 32'(pulses - p0), 32'd1);
    chk("ovr_value", 32'(last_val), 32'h1923);

    // reset discards a partial frame
    do_reset(3);
    p0 = pulses;
    show(3, 7'h06, 8);
    show(2, 7'h5B, 8);
    do_reset(2);
    show(1, 7'h4F, 8);
    show(0, 7'h66, 8);
    blank(12);
    chk("rstmid_nopulse", 32'(pulses - p0), 32'd0);
    show(3, 7'h77, 8);
    show(2, 7'h7C, 8);
    blank(10);
    chk("rstmid_pulse", 32'(pulses - p0), 32'd1);
    chk("rstmid_value", 32'(last_val), 32'hAB34);

    // random scanning: valid digits, bad patterns, blanks, ghosts
    for (int k = 0; k < 500; k++) begin
      int r;
      int h;
      r = int'($urandom_range(0, 9));
      h = int'($urandom_range(1, 9));
      if (r < 6) show(int'($urandom_range(0, 3)),
                      PAT[$urandom_range(0, 15)], h);
      else if (r == 6) show(int'($urandom_range(0, 3)),
                            7'($urandom), h);
      else if (r == 7) blank(h);
      else apply(4'($urandom), 7'($urandom), h);
    end
    blank(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
